sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched_if.sv | 23 ++
 rtl/sha256_msg_sched.sv | 88 ++++++++
 tb/tb_sha256_msg_sched.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sched_if.sv
// rtl/sha256_msg_sched_if.sv - block load / schedule-word stream bundle for the SHA-256 message scheduler
interface sha256_msg_sched_if;
   logic         start;
   logic [511:0] blk_in;
   logic         advance;
   logic [31:0]  w_t;
   logic [5:0]   t_idx;
   logic         valid;
   logic         busy;
   logic         done;

   // Producer of blocks and consumer of W words
   modport master (
      output start, blk_in, advance,
      input  w_t, t_idx, valid, busy, done
   );

   // The message scheduler itself
   modport slave (
      input  start, blk_in, advance,
      output w_t, t_idx, valid, busy, done
   );
endinterface

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - SHA-256 message schedule generator, one W word per advance
module sha256_msg_sched (
   input  logic              clk,
   input  logic              rst_n,
   sha256_msg_sched_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] r [0:15];
   logic [5:0]  t_q;
   logic        valid_q;
   logic        busy_q;
   logic        done_q;
   logic [31:0] w_next;

   // Small sigma functions of the SHA-256 message expansion
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Next window word: W[t+16] from the current 16-word window (r[0] = W[t])
   always_comb begin
      w_next = sig1(r[14]) + r[9] + sig0(r[1]) + r[0];
   end

   // Load / expand / finish control; the window only moves when a word is consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         t_q     <= 6'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r[i] <= 32'd0;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int j = 0; j < 16; j++) begin
                     r[j] <= bus.blk_in[511 - 32*j -: 32];
                  end
                  t_q     <= 6'd0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (bus.advance) begin
                  if (t_q == 6'd63) begin
                     // Last word taken: keep the window and index frozen for a stable w_t
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     for (int i = 0; i < 15; i++) begin
                        r[i] <= r[i+1];
                     end
                     r[15] <= w_next;
                     t_q   <= t_q + 6'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.w_t   = r[0];
   assign bus.t_idx = t_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - scoreboard bench for the SHA-256 message scheduler
module tb_sha256_msg_sched;

   typedef struct {
      logic [5:0]  t;
      logic [31:0] w;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_mis;
   int   cyc;
   exp_t sb [$];
   logic [31:0] got [0:63];

   localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] ZERO_BLK = 512'h0;
   localparam logic [511:0] ALT_BLK  = {16{32'hdeadbeef}};

   sha256_msg_sched_if bus ();

   sha256_msg_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic push_sched(input logic [511:0] blk);
      logic [31:0] w [0:63];
      exp_t e;
      for (int j = 0; j < 16; j++) w[j] = blk[511 - 32*j -: 32];
      for (int t = 16; t < 64; t++) begin
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         e.t = 6'(t);
         e.w = w[t];
         sb.push_back(e);
      end
   endtask

   // Called just after a falling edge; leaves at the falling edge where valid should be 1
   task automatic load(input logic [511:0] blk);
      bus.start  = 1'b1;
      bus.blk_in = blk;
      push_sched(blk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic consume(input int duty, input int ign_at, input logic [511:0] ign_blk,
                          input int stop_at, output int cycles);
      int guard;
      guard  = 0;
      cycles = 0;
      while (sb.size() > 0) begin
         if (guard >= 5000) begin
            chk("timeout", 32'd0, 32'd1);
            sb.delete();
            break;
         end
         guard++;
         chk("valid", 32'(bus.valid), 32'd1);
         chk("busy", 32'(bus.busy), 32'd1);
         chk("t_idx", 32'(bus.t_idx), 32'(sb[0].t));
         chk("w_t", bus.w_t, sb[0].w);
         if (stop_at >= 0 && bus.t_idx == 6'(stop_at)) begin
            bus.advance = 1'b0;
            bus.start   = 1'b0;
            return;
         end
         bus.start = (ign_at >= 0 && bus.t_idx == 6'(ign_at));
         if (bus.start) bus.blk_in = ign_blk;
         bus.advance = ($urandom_range(0, 99) < duty);
         if (bus.advance) begin
            got[bus.t_idx] = bus.w_t;
            void'(sb.pop_front());
         end
         @(negedge clk);
         cycles++;
      end
      bus.advance = 1'b0;
      bus.start   = 1'b0;
   endtask

   task automatic chk_done_pulse(input string tag);
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_valid_low"}, 32'(bus.valid), 32'd0);
      chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      bus.start   = 1'b0;
      bus.advance = 1'b0;
      bus.blk_in  = '0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_t_idx", 32'(bus.t_idx), 32'd0);
      chk("rst_w_t", bus.w_t, 32'd0);
      rst_n = 1'b1;

      // advance while idle does nothing
      bus.advance = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_valid", 32'(bus.valid), 32'd0);
         chk("idle_done", 32'(bus.done), 32'd0);
         chk("idle_t_idx", 32'(bus.t_idx), 32'd0);
         chk("idle_w_t", bus.w_t, 32'd0);
      end
      bus.advance = 1'b0;

      // all-zero block at full rate
      load(ZERO_BLK);
      consume(100, -1, ZERO_BLK, -1, cyc);
      chk("zero_latency", 32'(cyc + 1), 32'd65);
      chk_done_pulse("zero");
      @(negedge clk);
      chk("zero_done_clear", 32'(bus.done), 32'd0);

      // "abc" block at full rate, then a back-to-back stalled run started in the done cycle
      load(ABC_BLK);
      consume(100, -1, ABC_BLK, -1, cyc);
      chk_done_pulse("abc");
      chk("abc_w0", got[0], 32'h61626380);
      chk("abc_w15", got[15], 32'h00000018);
      chk("abc_w16", got[16], 32'h61626380);
      chk("abc_w17", got[17], 32'h000f0000);
      load(ABC_BLK);
      consume(30, 10, ALT_BLK, -1, cyc);
      chk_done_pulse("stall");
      @(negedge clk);
      chk("stall_done_clear", 32'(bus.done), 32'd0);

      // asynchronous reset in the middle of a block
      load(ABC_BLK);
      consume(100, -1, ABC_BLK, 20, cyc);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.valid), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_t_idx", 32'(bus.t_idx), 32'd0);
      chk("arst_w_t", bus.w_t, 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(bus.valid), 32'd0);
         chk("post_rst_t_idx", 32'(bus.t_idx), 32'd0);
         chk("post_rst_w_t", bus.w_t, 32'd0);
      end

      // recovery after reset with a medium duty
      load(ABC_BLK);
      consume(50, -1, ABC_BLK, -1, cyc);
      chk_done_pulse("recover");
      @(negedge clk);
      chk("recover_done_clear", 32'(bus.done), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
